// File: rtl/wb_arbiter.sv
// Two-master Wishbone pipelined arbiter: round-robin ownership of one shared slave,
// with a mandatory idle cycle between owners and responses steered to the owner only.
module wb_arbiter #(
    parameter int AW = 30,
    parameter int DW = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,

    input  logic              i_m0_cyc,
    input  logic              i_m0_stb,
    input  logic              i_m0_we,
    input  logic [AW-1:0]     i_m0_addr,
    input  logic [DW-1:0]     i_m0_data,
    input  logic [DW/8-1:0]   i_m0_sel,
    output logic              o_m0_stall,
    output logic              o_m0_ack,
    output logic              o_m0_err,
    output logic [DW-1:0]     o_m0_data,

    input  logic              i_m1_cyc,
    input  logic              i_m1_stb,
    input  logic              i_m1_we,
    input  logic [AW-1:0]     i_m1_addr,
    input  logic [DW-1:0]     i_m1_data,
    input  logic [DW/8-1:0]   i_m1_sel,
    output logic              o_m1_stall,
    output logic              o_m1_ack,
    output logic              o_m1_err,
    output logic [DW-1:0]     o_m1_data,

    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    output logic              o_wb_we,
    output logic [AW-1:0]     o_wb_addr,
    output logic [DW-1:0]     o_wb_data,
    output logic [DW/8-1:0]   o_wb_sel,
    input  logic              i_wb_stall,
    input  logic              i_wb_ack,
    input  logic              i_wb_err,
    input  logic [DW-1:0]     i_wb_data,

    output logic [1:0]        o_grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic       last_q, last_d;    // 1 = m1 owned the bus most recently

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                // On contention, m0 wins only if m1 was the previous owner.
                if (i_m0_cyc && (!i_m1_cyc || last_q)) begin
                    state_d = GNT0;
                    grant_d = 2'b01;
                    last_d  = 1'b0;
                end else if (i_m1_cyc) begin
                    state_d = GNT1;
                    grant_d = 2'b10;
                    last_d  = 1'b1;
                end
            end
            GNT0: begin
                if (!i_m0_cyc) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                end
            end
            GNT1: begin
                if (!i_m1_cyc) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign o_grant = grant_q;

    logic own0, own1;
    assign own0 = (state_q == GNT0);
    assign own1 = (state_q == GNT1);

    always_comb begin
        o_wb_cyc  = 1'b0;
        o_wb_stb  = 1'b0;
        o_wb_we   = 1'b0;
        o_wb_addr = '0;
        o_wb_data = '0;
        o_wb_sel  = '0;
        if (own0) begin
            o_wb_cyc  = i_m0_cyc;
            o_wb_stb  = i_m0_stb;
            o_wb_we   = i_m0_we;
            o_wb_addr = i_m0_addr;
            o_wb_data = i_m0_data;
            o_wb_sel  = i_m0_sel;
        end else if (own1) begin
            o_wb_cyc  = i_m1_cyc;
            o_wb_stb  = i_m1_stb;
            o_wb_we   = i_m1_we;
            o_wb_addr = i_m1_addr;
            o_wb_data = i_m1_data;
            o_wb_sel  = i_m1_sel;
        end
    end

    // Responses in IDLE (including late acks after a reset abort) reach nobody.
    assign o_m0_stall = own0 ? i_wb_stall : 1'b1;
    assign o_m0_ack   = own0 & i_wb_ack;
    assign o_m0_err   = own0 & i_wb_err;
    assign o_m0_data  = i_wb_data;

    assign o_m1_stall = own1 ? i_wb_stall : 1'b1;
    assign o_m1_ack   = own1 & i_wb_ack;
    assign o_m1_err   = own1 & i_wb_err;
    assign o_m1_data  = i_wb_data;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: single master, contention, fairness, stall, error
// and reset-abort scenarios with hand-computed expectations.
module tb_wb_arbiter;

    localparam int AW = 30;
    localparam int DW = 32;

    logic            i_clk = 1'b0;
    logic            i_reset;
    logic            i_m0_cyc, i_m0_stb, i_m0_we;
    logic [AW-1:0]   i_m0_addr;
    logic [DW-1:0]   i_m0_data;
    logic [DW/8-1:0] i_m0_sel;
    logic            o_m0_stall, o_m0_ack, o_m0_err;
    logic [DW-1:0]   o_m0_data;
    logic            i_m1_cyc, i_m1_stb, i_m1_we;
    logic [AW-1:0]   i_m1_addr;
    logic [DW-1:0]   i_m1_data;
    logic [DW/8-1:0] i_m1_sel;
    logic            o_m1_stall, o_m1_ack, o_m1_err;
    logic [DW-1:0]   o_m1_data;
    logic            o_wb_cyc, o_wb_stb, o_wb_we;
    logic [AW-1:0]   o_wb_addr;
    logic [DW-1:0]   o_wb_data;
    logic [DW/8-1:0] o_wb_sel;
    logic            i_wb_stall, i_wb_ack, i_wb_err;
    logic [DW-1:0]   i_wb_data;
    logic [1:0]      o_grant;

    int checks = 0;
    int failures = 0;

    wb_arbiter #(.AW(AW), .DW(DW)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_m0_cyc(i_m0_cyc), .i_m0_stb(i_m0_stb), .i_m0_we(i_m0_we),
        .i_m0_addr(i_m0_addr), .i_m0_data(i_m0_data), .i_m0_sel(i_m0_sel),
        .o_m0_stall(o_m0_stall), .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err), .o_m0_data(o_m0_data),
        .i_m1_cyc(i_m1_cyc), .i_m1_stb(i_m1_stb), .i_m1_we(i_m1_we),
        .i_m1_addr(i_m1_addr), .i_m1_data(i_m1_data), .i_m1_sel(i_m1_sel),
        .o_m1_stall(o_m1_stall), .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err), .o_m1_data(o_m1_data),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
        .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_data(i_wb_data),
        .o_grant(o_grant)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [1:0] exp_gnt;

    initial begin
        i_reset = 1'b1;
        i_m0_cyc = 0; i_m0_stb = 0; i_m0_we = 0; i_m0_addr = '0; i_m0_data = '0; i_m0_sel = '0;
        i_m1_cyc = 0; i_m1_stb = 0; i_m1_we = 0; i_m1_addr = '0; i_m1_data = '0; i_m1_sel = '0;
        i_wb_stall = 0; i_wb_ack = 1; i_wb_err = 1; i_wb_data = 32'hDEADBEEF;
        tick();
        tick();
        settle();
        check_eq("rst_grant", o_grant, 2'b00);
        check_eq("rst_wb_cyc", o_wb_cyc, 1'b0);
        check_eq("rst_wb_stb", o_wb_stb, 1'b0);
        check_eq("rst_m0_stall", o_m0_stall, 1'b1);
        check_eq("rst_m1_stall", o_m1_stall, 1'b1);
        check_eq("rst_m0_ack", o_m0_ack, 1'b0);
        check_eq("rst_m1_err", o_m1_err, 1'b0);
        i_reset = 1'b0; i_wb_ack = 0; i_wb_err = 0;

        // Single master write
        tick();
        i_m0_cyc = 1; i_m0_stb = 1; i_m0_we = 1; i_m0_addr = 30'h10; i_m0_data = 32'hA5; i_m0_sel = 4'hF;
        settle();
        check_eq("single_stall_n", o_m0_stall, 1'b1);
        check_eq("single_cyc_n", o_wb_cyc, 1'b0);
        tick();
        settle();
        check_eq("single_grant", o_grant, 2'b01);
        check_eq("single_wb_cyc", o_wb_cyc, 1'b1);
        check_eq("single_wb_we", o_wb_we, 1'b1);
        check_eq("single_wb_addr", o_wb_addr, 30'h10);
        check_eq("single_wb_data", o_wb_data, 32'hA5);
        check_eq("single_wb_sel", o_wb_sel, 4'hF);
        check_eq("single_m0_stall", o_m0_stall, 1'b0);
        i_wb_ack = 1;
        settle();
        check_eq("single_m0_ack", o_m0_ack, 1'b1);
        check_eq("single_m1_ack", o_m1_ack, 1'b0);
        check_eq("single_m0_data", o_m0_data, 32'hDEADBEEF);
        check_eq("single_m1_data", o_m1_data, 32'hDEADBEEF);
        tick();
        i_wb_ack = 0; i_m0_cyc = 0; i_m0_stb = 0; i_m0_we = 0;
        tick();
        settle();
        check_eq("single_release", o_grant, 2'b00);

        // Simultaneous requests after reset
        i_reset = 1;
        tick();
        i_reset = 0;
        i_m0_cyc = 1; i_m0_stb = 1; i_m1_cyc = 1; i_m1_stb = 1;
        i_m1_addr = 30'h44; i_m0_addr = 30'h33;
        tick();
        settle();
        check_eq("both_first_m0", o_grant, 2'b01);
        check_eq("both_addr_m0", o_wb_addr, 30'h33);
        check_eq("both_m1_stall", o_m1_stall, 1'b1);
        i_m0_cyc = 0; i_m0_stb = 0;
        tick();
        settle();
        check_eq("both_idle_gap", o_grant, 2'b00);
        check_eq("both_idle_cyc", o_wb_cyc, 1'b0);
        tick();
        settle();
        check_eq("both_then_m1", o_grant, 2'b10);
        check_eq("both_addr_m1", o_wb_addr, 30'h44);
        check_eq("both_m1_stall_own", o_m1_stall, 1'b0);
        i_m1_cyc = 0; i_m1_stb = 0;
        tick();

        // Fairness: both request continuously; owner releases after each burst
        i_m0_cyc = 1; i_m0_stb = 1; i_m1_cyc = 1; i_m1_stb = 1;
        exp_gnt = 2'b01;
        tick();
        for (int b = 0; b < 8; b++) begin
            settle();
            check_eq($sformatf("fair_burst%0d", b), o_grant, exp_gnt);
            tick();
            if (exp_gnt == 2'b01) i_m0_cyc = 0; else i_m1_cyc = 0;
            tick();
            settle();
            check_eq($sformatf("fair_gap%0d", b), o_grant, 2'b00);
            i_m0_cyc = 1; i_m1_cyc = 1;
            tick();
            exp_gnt = (exp_gnt == 2'b01) ? 2'b10 : 2'b01;
        end
        // Last burst was m1's; release everything.
        i_m0_cyc = 0; i_m0_stb = 0; i_m1_cyc = 0; i_m1_stb = 0;
        tick();
        tick();

        // Slave stall
        i_m0_cyc = 1; i_m0_stb = 1; i_m0_we = 1; i_m0_addr = 30'h20; i_m0_data = 32'h1234;
        tick();
        i_wb_stall = 1;
        for (int s = 0; s < 3; s++) begin
            settle();
            check_eq($sformatf("stall_m0_%0d", s), o_m0_stall, 1'b1);
            check_eq($sformatf("stall_m1_%0d", s), o_m1_stall, 1'b1);
            check_eq($sformatf("stall_addr_%0d", s), o_wb_addr, 30'h20);
            check_eq($sformatf("stall_stb_%0d", s), o_wb_stb, 1'b1);
            tick();
        end
        i_wb_stall = 0;
        settle();
        check_eq("stall_m0_free", o_m0_stall, 1'b0);
        check_eq("stall_m1_still", o_m1_stall, 1'b1);
        i_m0_cyc = 0; i_m0_stb = 0; i_m0_we = 0;
        tick();
        tick();

        // Error on m1 read
        i_m1_cyc = 1; i_m1_stb = 1; i_m1_we = 0; i_m1_addr = 30'h30;
        tick();
        settle();
        check_eq("err_grant", o_grant, 2'b10);
        check_eq("err_wb_we", o_wb_we, 1'b0);
        i_wb_err = 1;
        settle();
        check_eq("err_m1", o_m1_err, 1'b1);
        check_eq("err_m0", o_m0_err, 1'b0);
        tick();
        i_wb_err = 0;
        settle();
        check_eq("err_hold1", o_grant, 2'b10);
        tick();
        settle();
        check_eq("err_hold2", o_grant, 2'b10);
        i_m1_cyc = 0; i_m1_stb = 0;
        tick();
        settle();
        check_eq("err_release", o_grant, 2'b00);
        i_wb_ack = 1; i_wb_err = 1;
        settle();
        check_eq("idle_drop_ack0", o_m0_ack, 1'b0);
        check_eq("idle_drop_ack1", o_m1_ack, 1'b0);
        check_eq("idle_drop_err1", o_m1_err, 1'b0);
        i_wb_ack = 0; i_wb_err = 0;

        // Reset mid-burst with an ack still pending
        i_m0_cyc = 1; i_m0_stb = 1; i_m0_addr = 30'h50;
        tick();
        settle();
        check_eq("abort_grant_pre", o_grant, 2'b01);
        i_reset = 1;
        tick();
        i_reset = 0;
        settle();
        check_eq("abort_grant", o_grant, 2'b00);
        check_eq("abort_wb_cyc", o_wb_cyc, 1'b0);
        i_wb_ack = 1;
        settle();
        check_eq("abort_late_ack", o_m0_ack, 1'b0);
        check_eq("abort_m0_stall", o_m0_stall, 1'b1);
        i_wb_ack = 0;
        i_m0_cyc = 0; i_m0_stb = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
